// File: rtl/dac_spi_serializer_if.sv
// Sample-in / DAC-out bundle for dac_spi_serializer.
//   enable, sample_in, sample_stb : sample source side (driven by master)
//   dac_cs_n, dac_sclk, dac_mosi   : SPI pins toward the DAC (driven by slave)
//   busy, frame_done, drop_cnt     : status (driven by slave)
interface dac_spi_serializer_if #(
  parameter int M = 16
);
  logic         enable;
  logic [M-1:0] sample_in;
  logic         sample_stb;
  logic         dac_cs_n;
  logic         dac_sclk;
  logic         dac_mosi;
  logic         busy;
  logic         frame_done;
  logic [15:0]  drop_cnt;

  modport slave (
    input  enable, sample_in, sample_stb,
    output dac_cs_n, dac_sclk, dac_mosi, busy, frame_done, drop_cnt
  );

  modport master (
    output enable, sample_in, sample_stb,
    input  dac_cs_n, dac_sclk, dac_mosi, busy, frame_done, drop_cnt
  );
endinterface

// File: rtl/dac_spi_serializer.sv
// Serialises signed waveform samples into 24-bit SPI frames {CMD, offset-binary
// sample} for a DAC. A one-entry buffer decouples the sample strobe from the
// frame timing; overwritten samples are counted in a saturating drop counter.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - dac_spi_serializer_if.slave: enable/sample_in/sample_stb in,
//          dac_cs_n/dac_sclk/dac_mosi/busy/frame_done/drop_cnt out (all registered)
module dac_spi_serializer #(
  parameter int unsigned M       = 16,
  parameter int unsigned CLK_DIV = 2,
  parameter logic [7:0]  CMD     = 8'h30
) (
  input  logic                       clk,
  input  logic                       rst,
  dac_spi_serializer_if.slave        bus
);

  localparam int unsigned FW       = 8 + M;
  localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_e;

  state_e         state_q, state_d;
  logic           buf_valid_q, buf_valid_d;
  logic [M-1:0]   buf_data_q, buf_data_d;
  logic [FW-1:0]  shreg_q, shreg_d;
  logic [4:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     div_q, div_d;
  logic           cs_n_q, cs_n_d;
  logic           sclk_q, sclk_d;
  logic           busy_q, busy_d;
  logic           frame_done_q, frame_done_d;
  logic [15:0]    drop_cnt_q, drop_cnt_d;

  logic accept;
  logic load;
  logic div_last;

  always_comb begin
    state_d      = state_q;
    buf_valid_d  = buf_valid_q;
    buf_data_d   = buf_data_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    div_d        = div_q;
    cs_n_d       = cs_n_q;
    sclk_d       = sclk_q;
    drop_cnt_d   = drop_cnt_q;
    frame_done_d = 1'b0;

    accept   = bus.enable & bus.sample_stb;
    load     = (state_q == IDLE) & buf_valid_q & bus.enable;
    div_last = (div_q == DIV_LAST);

    // A strobe that lands on the load edge refills the buffer rather than
    // overwriting a pending sample, so it is not a drop.
    if (!bus.enable) begin
      buf_valid_d = 1'b0;
    end else if (accept) begin
      buf_valid_d = 1'b1;
      buf_data_d  = {~bus.sample_in[M-1], bus.sample_in[M-2:0]};
    end else if (load) begin
      buf_valid_d = 1'b0;
    end

    if (accept && buf_valid_q && !load && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end

    // dac_mosi is the shift register MSB; shifting on each falling sclk edge
    // presents the next lower bit, and the register is empty by HOLD.
    unique case (state_q)
      IDLE: begin
        if (load) begin
          state_d = SETUP;
          shreg_d = {CMD, buf_data_q};
          cs_n_d  = 1'b0;
          div_d   = '0;
        end
      end
      SETUP: begin
        if (div_last) begin
          state_d   = SHIFT;
          div_d     = '0;
          sclk_d    = 1'b1;
          bit_cnt_d = 5'(FW - 1);
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      SHIFT: begin
        if (!div_last) begin
          div_d = div_q + 8'd1;
        end else begin
          div_d = '0;
          if (sclk_q) begin
            sclk_d  = 1'b0;
            shreg_d = {shreg_q[FW-2:0], 1'b0};
          end else if (bit_cnt_q == '0) begin
            state_d = HOLD;
            cs_n_d  = 1'b1;
            shreg_d = '0;
          end else begin
            sclk_d    = 1'b1;
            bit_cnt_d = bit_cnt_q - 5'd1;
          end
        end
      end
      HOLD: begin
        if (div_last) begin
          state_d      = IDLE;
          div_d        = '0;
          frame_done_d = 1'b1;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      buf_valid_q  <= 1'b0;
      buf_data_q   <= '0;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      div_q        <= '0;
      cs_n_q       <= 1'b1;
      sclk_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      buf_valid_q  <= buf_valid_d;
      buf_data_q   <= buf_data_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      div_q        <= div_d;
      cs_n_q       <= cs_n_d;
      sclk_q       <= sclk_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign bus.dac_cs_n   = cs_n_q;
  assign bus.dac_sclk   = sclk_q;
  assign bus.dac_mosi   = shreg_q[FW-1];
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.drop_cnt   = drop_cnt_q;

endmodule
